// File: rtl/bus_master_port_if.sv
// Bus-wide widths/payload types and the client+bus signal bundle for bus_master_port.
// master modport is the port's own view; slave modport is the view of whoever drives client and memory side.
package bus_pkg;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic                  we;
        logic                  split;
    } cmd_t;
endpackage

interface bus_master_port_if;
    import bus_pkg::*;

    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [DATA_WIDTH-1:0] cmd_wdata_i;
    logic                  cmd_we_i;
    logic                  cmd_split_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_err_o;
    logic                  rsp_timeout_o;

    logic                  valid_o;
    logic [ADDR_WIDTH-1:0] addr_o;
    logic [DATA_WIDTH-1:0] wdata_o;
    logic                  we_o;
    logic                  split_start_o;
    logic                  ready_i;
    logic [DATA_WIDTH-1:0] rdata_i;
    logic                  err_i;
    logic                  split_ready_i;

    modport master (
        input  cmd_valid_i, cmd_addr_i, cmd_wdata_i, cmd_we_i, cmd_split_i,
        output cmd_ready_o,
        input  rsp_ready_i,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        output valid_o, addr_o, wdata_o, we_o, split_start_o,
        input  ready_i, rdata_i, err_i, split_ready_i
    );

    modport slave (
        output cmd_valid_i, cmd_addr_i, cmd_wdata_i, cmd_we_i, cmd_split_i,
        input  cmd_ready_o,
        output rsp_ready_i,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        input  valid_o, addr_o, wdata_o, we_o, split_start_o,
        output ready_i, rdata_i, err_i, split_ready_i
    );
endinterface

// File: rtl/bus_master_port.sv
// Single-outstanding bus initiator: client command -> bus request -> completion -> client response.
// Optional WAIT-state timeout is enabled by defining BUS_MASTER_TIMEOUT_EN.
module bus_master_port
    import bus_pkg::*;
`ifdef BUS_MASTER_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 32
)
`endif
(
    input logic               clk_i,
    input logic               rst_i,
    bus_master_port_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                state_q, state_d;
    cmd_t                  cmd_q, cmd_d;
    logic                  valid_q, valid_d;
    logic                  split_start_q, split_start_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

`ifdef BUS_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             rsp_timeout_q, rsp_timeout_d;
`endif

    // Next state plus next value of every registered output
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        valid_d       = 1'b0;
        split_start_d = 1'b0;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
`ifdef BUS_MASTER_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid_i && cmd_ready_q) begin
                    cmd_d.addr    = bus.cmd_addr_i;
                    cmd_d.wdata   = bus.cmd_wdata_i;
                    cmd_d.we      = bus.cmd_we_i;
                    cmd_d.split   = bus.cmd_split_i && !bus.cmd_we_i;
                    valid_d       = 1'b1;
                    split_start_d = bus.cmd_split_i && !bus.cmd_we_i;
                    state_d       = S_REQ;
                end
            end
            S_REQ: begin
`ifdef BUS_MASTER_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // ready_i takes priority over a coincident split_ready_i
                if (bus.ready_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.err_i;
                    rsp_rdata_d = (!cmd_q.we && !bus.err_i) ? bus.rdata_i : '0;
                    state_d     = S_RESP;
                end else if (bus.split_ready_i && cmd_q.split) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = bus.rdata_i;
                    state_d     = S_RESP;
                end
`ifdef BUS_MASTER_TIMEOUT_EN
                else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    state_d       = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
`endif
            end
            S_RESP: begin
                if (bus.rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
`ifdef BUS_MASTER_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            cmd_q         <= '0;
            valid_q       <= 1'b0;
            split_start_q <= 1'b0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            valid_q       <= valid_d;
            split_start_q <= split_start_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
`ifdef BUS_MASTER_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

    assign bus.cmd_ready_o   = cmd_ready_q;
    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.rsp_rdata_o   = rsp_rdata_q;
    assign bus.rsp_err_o     = rsp_err_q;
    assign bus.valid_o       = valid_q;
    assign bus.split_start_o = split_start_q;
    assign bus.addr_o        = cmd_q.addr;
    assign bus.wdata_o       = cmd_q.wdata;
    assign bus.we_o          = cmd_q.we;
`ifdef BUS_MASTER_TIMEOUT_EN
    assign bus.rsp_timeout_o = rsp_timeout_q;
`else
    assign bus.rsp_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: the bench plays both client and memory slave.
// Inputs change and outputs are sampled on the falling edge, away from the active rising edge.
module tb_bus_master_port;
    logic clk_i = 1'b0;
    logic rst_i;
    int   n_tests = 0;
    int   n_fail  = 0;

    bus_master_port_if bif();

`ifdef BUS_MASTER_TIMEOUT_EN
    bus_master_port #(.TIMEOUT_CYCLES(8)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bif));
`else
    bus_master_port dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bif));
`endif

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one command while the port is idle; it is taken on the next rising edge
    task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic we, input logic split);
        bif.cmd_valid_i = 1'b1;
        bif.cmd_addr_i  = addr;
        bif.cmd_wdata_i = wdata;
        bif.cmd_we_i    = we;
        bif.cmd_split_i = split;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i             = 1'b1;
        bif.cmd_valid_i   = 1'b0;
        bif.cmd_addr_i    = '0;
        bif.cmd_wdata_i   = '0;
        bif.cmd_we_i      = 1'b0;
        bif.cmd_split_i   = 1'b0;
        bif.rsp_ready_i   = 1'b1;
        bif.ready_i       = 1'b0;
        bif.rdata_i       = '0;
        bif.err_i         = 1'b0;
        bif.split_ready_i = 1'b0;

        repeat (2) step();
        chk("rst_cmd_ready", 32'(bif.cmd_ready_o), 32'd1);
        chk("rst_rsp_valid", 32'(bif.rsp_valid_o), 32'd0);
        chk("rst_valid",     32'(bif.valid_o),     32'd0);
        chk("rst_addr",      bif.addr_o,           32'd0);
        rst_i = 1'b0;
        step();
        chk("rel_cmd_ready", 32'(bif.cmd_ready_o), 32'd1);

        // Write 0x10 <- 0xDEADBEEF
        issue(32'h10, 32'hDEADBEEF, 1'b1, 1'b1);
        step();
        bif.cmd_valid_i = 1'b0;
        chk("wr_valid",       32'(bif.valid_o),       32'd1);
        chk("wr_we",          32'(bif.we_o),          32'd1);
        chk("wr_addr",        bif.addr_o,             32'h10);
        chk("wr_wdata",       bif.wdata_o,            32'hDEADBEEF);
        chk("wr_split_start", 32'(bif.split_start_o), 32'd0);
        chk("wr_cmd_ready",   32'(bif.cmd_ready_o),   32'd0);
        step();
        chk("wr_valid_pulse", 32'(bif.valid_o), 32'd0);
        bif.ready_i = 1'b1;
        bif.rdata_i = 32'h0BAD0BAD;
        step();
        bif.ready_i = 1'b0;
        chk("wr_rsp_valid",   32'(bif.rsp_valid_o),   32'd1);
        chk("wr_rsp_err",     32'(bif.rsp_err_o),     32'd0);
        chk("wr_rsp_rdata",   bif.rsp_rdata_o,        32'd0);
        chk("wr_rsp_timeout", 32'(bif.rsp_timeout_o), 32'd0);
        step();
        chk("wr_done_rsp_valid", 32'(bif.rsp_valid_o), 32'd0);
        chk("wr_done_cmd_ready", 32'(bif.cmd_ready_o), 32'd1);

        // Non-split read of 0x10
        issue(32'h10, 32'h0, 1'b0, 1'b0);
        step();
        bif.cmd_valid_i = 1'b0;
        chk("rd_valid", 32'(bif.valid_o), 32'd1);
        chk("rd_we",    32'(bif.we_o),    32'd0);
        step();
        chk("rd_valid_pulse", 32'(bif.valid_o), 32'd0);
        bif.ready_i = 1'b1;
        bif.rdata_i = 32'hDEADBEEF;
        step();
        bif.ready_i = 1'b0;
        bif.rdata_i = '0;
        chk("rd_rsp_valid", 32'(bif.rsp_valid_o), 32'd1);
        chk("rd_rsp_rdata", bif.rsp_rdata_o,      32'hDEADBEEF);
        chk("rd_rsp_err",   32'(bif.rsp_err_o),   32'd0);
        chk("rd_valid_once", 32'(bif.valid_o),    32'd0);
        step();
        chk("rd_done_cmd_ready", 32'(bif.cmd_ready_o), 32'd1);

        // Completions while idle, and split_ready on a non-split read, are ignored
        bif.ready_i       = 1'b1;
        bif.split_ready_i = 1'b1;
        step();
        bif.ready_i       = 1'b0;
        bif.split_ready_i = 1'b0;
        chk("idle_stray_rsp_valid", 32'(bif.rsp_valid_o), 32'd0);
        chk("idle_stray_cmd_ready", 32'(bif.cmd_ready_o), 32'd1);
        issue(32'h20, 32'h0, 1'b0, 1'b0);
        step();
        bif.cmd_valid_i = 1'b0;
        step();
        bif.split_ready_i = 1'b1;
        bif.rdata_i       = 32'h55;
        step();
        bif.split_ready_i = 1'b0;
        chk("nonsplit_ignore_split_ready", 32'(bif.rsp_valid_o), 32'd0);
        bif.ready_i = 1'b1;
        bif.rdata_i = 32'hA5A5A5A5;
        step();
        bif.ready_i = 1'b0;
        chk("nonsplit_rsp_valid", 32'(bif.rsp_valid_o), 32'd1);
        chk("nonsplit_rsp_rdata", bif.rsp_rdata_o,      32'hA5A5A5A5);
        step();

        // Split read of 0x10, completed by split_ready_i seven cycles after the request
        issue(32'h10, 32'h0, 1'b0, 1'b1);
        step();
        bif.cmd_valid_i = 1'b0;
        chk("sp_valid",       32'(bif.valid_o),       32'd1);
        chk("sp_split_start", 32'(bif.split_start_o), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("sp_wait_rsp_valid",   32'(bif.rsp_valid_o),   32'd0);
            chk("sp_wait_split_start", 32'(bif.split_start_o), 32'd0);
        end
        step();
        bif.split_ready_i = 1'b1;
        bif.rdata_i       = 32'hDEADBEEF;
        step();
        bif.split_ready_i = 1'b0;
        bif.rdata_i       = '0;
        chk("sp_rsp_valid", 32'(bif.rsp_valid_o), 32'd1);
        chk("sp_rsp_rdata", bif.rsp_rdata_o,      32'hDEADBEEF);
        chk("sp_rsp_err",   32'(bif.rsp_err_o),   32'd0);
        step();

        // Out-of-range read rejected by the slave, non-split then split
        for (int s = 0; s < 2; s++) begin
            issue(32'h1000, 32'h0, 1'b0, s[0]);
            step();
            bif.cmd_valid_i = 1'b0;
            chk("err_split_start", 32'(bif.split_start_o), 32'(s));
            step();
            bif.ready_i = 1'b1;
            bif.err_i   = 1'b1;
            bif.rdata_i = 32'h12345678;
            step();
            bif.ready_i = 1'b0;
            bif.err_i   = 1'b0;
            chk("err_rsp_valid", 32'(bif.rsp_valid_o), 32'd1);
            chk("err_rsp_err",   32'(bif.rsp_err_o),   32'd1);
            chk("err_rsp_rdata", bif.rsp_rdata_o,      32'd0);
            step();
        end

        // ready_i+err_i and split_ready_i together on a split read: ready_i wins
        issue(32'h10, 32'h0, 1'b0, 1'b1);
        step();
        bif.cmd_valid_i = 1'b0;
        step();
        bif.ready_i       = 1'b1;
        bif.err_i         = 1'b1;
        bif.split_ready_i = 1'b1;
        bif.rdata_i       = 32'h77;
        step();
        bif.ready_i       = 1'b0;
        bif.err_i         = 1'b0;
        bif.split_ready_i = 1'b0;
        chk("tie_rsp_err",   32'(bif.rsp_err_o), 32'd1);
        chk("tie_rsp_rdata", bif.rsp_rdata_o,    32'd0);
        step();

        // Response back-pressure for ten cycles with stray inputs
        bif.rsp_ready_i = 1'b0;
        issue(32'h10, 32'h0, 1'b0, 1'b0);
        step();
        bif.cmd_valid_i = 1'b0;
        step();
        bif.ready_i = 1'b1;
        bif.rdata_i = 32'hDEADBEEF;
        step();
        bif.ready_i     = 1'b0;
        bif.rdata_i     = '0;
        issue(32'h99, 32'h1, 1'b1, 1'b0);
        chk("bp_rsp_valid_first", 32'(bif.rsp_valid_o), 32'd1);
        for (int i = 0; i < 10; i++) begin
            bif.split_ready_i = (i == 3);
            step();
            chk("bp_rsp_valid", 32'(bif.rsp_valid_o), 32'd1);
            chk("bp_rsp_rdata", bif.rsp_rdata_o,      32'hDEADBEEF);
            chk("bp_rsp_err",   32'(bif.rsp_err_o),   32'd0);
            chk("bp_cmd_ready", 32'(bif.cmd_ready_o), 32'd0);
            chk("bp_valid",     32'(bif.valid_o),     32'd0);
            chk("bp_addr_held", bif.addr_o,           32'h10);
        end
        bif.split_ready_i = 1'b0;
        bif.cmd_valid_i   = 1'b0;
        bif.rsp_ready_i   = 1'b1;
        step();
        chk("bp_done_rsp_valid", 32'(bif.rsp_valid_o), 32'd0);
        chk("bp_done_cmd_ready", 32'(bif.cmd_ready_o), 32'd1);

        // Reset in WAIT drops the transaction
        issue(32'h10, 32'h0, 1'b0, 1'b0);
        step();
        bif.cmd_valid_i = 1'b0;
        step();
        rst_i = 1'b1;
        step();
        rst_i       = 1'b0;
        chk("rstw_cmd_ready", 32'(bif.cmd_ready_o), 32'd1);
        chk("rstw_rsp_valid", 32'(bif.rsp_valid_o), 32'd0);
        chk("rstw_valid",     32'(bif.valid_o),     32'd0);
        bif.ready_i = 1'b1;
        step();
        bif.ready_i = 1'b0;
        chk("rstw_late_ready", 32'(bif.rsp_valid_o), 32'd0);
        step();

`ifdef BUS_MASTER_TIMEOUT_EN
        // Silent slave: forced error after eight WAIT cycles
        issue(32'h10, 32'h0, 1'b0, 1'b0);
        step();
        bif.cmd_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("tmo_wait_rsp_valid", 32'(bif.rsp_valid_o), 32'd0);
        end
        step();
        chk("tmo_rsp_valid",   32'(bif.rsp_valid_o),   32'd1);
        chk("tmo_rsp_err",     32'(bif.rsp_err_o),     32'd1);
        chk("tmo_rsp_timeout", 32'(bif.rsp_timeout_o), 32'd1);
        chk("tmo_rsp_rdata",   bif.rsp_rdata_o,        32'd0);
        step();

        // Completion on the limit cycle beats the timeout
        issue(32'h10, 32'h0, 1'b0, 1'b0);
        step();
        bif.cmd_valid_i = 1'b0;
        for (int i = 0; i < 7; i++) step();
        step();
        bif.ready_i = 1'b1;
        bif.rdata_i = 32'h1;
        step();
        bif.ready_i = 1'b0;
        chk("lim_rsp_valid",   32'(bif.rsp_valid_o),   32'd1);
        chk("lim_rsp_timeout", 32'(bif.rsp_timeout_o), 32'd0);
        chk("lim_rsp_err",     32'(bif.rsp_err_o),     32'd0);
        chk("lim_rsp_rdata",   bif.rsp_rdata_o,        32'h1);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
